tetris_input_ctrl: RTL and testbench

- Converts the raw USB keyboard keycode into discrete Tetris move actions, with delayed auto-shift (DAS) and auto-repeat (ARR).
- Input keycode comes from the Nios/CY7C67200 keycode PIO; auto-repeat timing uses the VGA frame tick.
- Output goes to the game-logic FSM through a one-entry valid/ready buffer.
- Lives inside `lab8`, between the keycode register and the piece-movement logic.

---
 rtl/tetris_pkg.sv | 43 ++++
 rtl/action_buffer.sv | 47 ++++
 rtl/tetris_input_ctrl.sv | 100 ++++++++++
 tb/tb_tetris_input_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared types for the Tetris keyboard front end: action codes, keycodes and
// the input-controller state encoding.
package tetris_pkg;

    typedef enum logic [2:0] {
        NONE      = 3'd0,
        LEFT      = 3'd1,
        RIGHT     = 3'd2,
        SOFT_DROP = 3'd3,
        ROTATE    = 3'd4,
        HARD_DROP = 3'd5
    } action_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        HOLD   = 2'd3
    } in_state_t;

    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    function automatic action_t key_to_action(input logic [7:0] code);
        case (code)
            KEY_A:     return LEFT;
            KEY_D:     return RIGHT;
            KEY_S:     return SOFT_DROP;
            KEY_W:     return ROTATE;
            KEY_SPACE: return HARD_DROP;
            default:   return NONE;
        endcase
    endfunction

    // Only movement keys auto-repeat; rotate and hard drop fire once per press.
    function automatic logic is_shift(input action_t act);
        return (act == LEFT) || (act == RIGHT) || (act == SOFT_DROP);
    endfunction

endpackage

// File: rtl/action_buffer.sv
// One-entry valid/ready output register. Presses overwrite a stalled entry,
// auto-repeats are dropped when it is stalled.
module action_buffer
    import tetris_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       wr_en,
    input  logic       wr_force,
    input  logic [2:0] wr_data,
    input  logic       ready,
    output logic       valid,
    output logic [2:0] data
);

    logic       valid_q, valid_d;
    logic [2:0] data_q, data_d;
    logic       accept;
    logic       write;

    always_comb begin
        accept  = valid_q && ready;
        write   = wr_en && (!valid_q || accept || wr_force);
        valid_d = valid_q;
        data_d  = data_q;
        if (write) begin
            valid_d = 1'b1;
            data_d  = wr_data;
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_q <= 1'b0;
            data_q  <= NONE;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/tetris_input_ctrl.sv
// Keycode to Tetris action converter with delayed auto-shift and auto-repeat
// paced by the VGA frame tick.
module tetris_input_ctrl
    import tetris_pkg::*;
#(
    parameter int DAS_FRAMES = 10,
    parameter int ARR_FRAMES = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       frame_tick,
    output logic [2:0] action,
    output logic       action_valid,
    input  logic       action_ready,
    output logic [1:0] dbg_state
);

    localparam logic [5:0] DAS_LAST = 6'(DAS_FRAMES);
    localparam logic [5:0] ARR_LAST = 6'(ARR_FRAMES);

    logic [7:0] key_q, key_d;
    logic [7:0] prev_q, prev_d;
    in_state_t  state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    action_t    cur_act;
    logic       press;
    logic       evt_en;
    logic       evt_force;

    always_comb begin
        key_d     = keycode;
        prev_d    = key_q;
        cur_act   = key_to_action(key_q);
        press     = (cur_act != NONE) && (key_q != prev_q);
        state_d   = state_q;
        cnt_d     = cnt_q;
        evt_en    = 1'b0;
        evt_force = 1'b0;
        // Release beats press beats tick, so a tick landing on either is lost.
        if (cur_act == NONE) begin
            state_d = IDLE;
            cnt_d   = 6'd0;
        end else if (press) begin
            evt_en    = 1'b1;
            evt_force = 1'b1;
            cnt_d     = 6'd0;
            state_d   = is_shift(cur_act) ? DELAY : HOLD;
        end else if (frame_tick) begin
            case (state_q)
                DELAY: begin
                    if (cnt_q + 6'd1 == DAS_LAST) begin
                        evt_en  = 1'b1;
                        state_d = REPEAT;
                        cnt_d   = 6'd0;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                REPEAT: begin
                    if (cnt_q + 6'd1 == ARR_LAST) begin
                        evt_en = 1'b1;
                        cnt_d  = 6'd0;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_q   <= 8'h00;
            prev_q  <= 8'h00;
            state_q <= IDLE;
            cnt_q   <= 6'd0;
        end else begin
            key_q   <= key_d;
            prev_q  <= prev_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    action_buffer u_buf (
        .Clk      (Clk),
        .Reset    (Reset),
        .wr_en    (evt_en),
        .wr_force (evt_force),
        .wr_data  (cur_act),
        .ready    (action_ready),
        .valid    (action_valid),
        .data     (action)
    );

    assign dbg_state = state_q;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Bench for tetris_input_ctrl: directed scenarios plus random key/tick/ready
// traffic, checked against a frame-counting reference model.
module tb_tetris_input_ctrl;

    localparam int DAS = 10;
    localparam int ARR = 2;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    logic       Clk;
    logic       Reset;
    logic [7:0] keycode;
    logic       frame_tick;
    logic [2:0] action;
    logic       action_valid;
    logic       action_ready;
    logic [1:0] dbg_state;

    int errors = 0;
    int checks = 0;
    int xfer_cnt = 0;
    logic mon_en = 1'b0;

    logic [2:0] exp_q[$];

    // Reference model state: keycode seen at the last two edges, held action,
    // frame ticks counted since the press and the mirrored output slot.
    logic [7:0] mk_q = 8'h00;
    logic [7:0] mk_prev = 8'h00;
    logic [2:0] m_held = 3'd0;
    int         m_ticks = 0;
    logic       m_valid = 1'b0;
    logic [2:0] m_data = 3'd0;
    logic       exp_valid_now = 1'b0;
    logic [2:0] exp_data_now = 3'd0;
    logic [2:0] m_act;
    logic       m_ev, m_evp, m_acc;

    logic [7:0] keys [8] = '{8'h00, 8'h04, 8'h07, 8'h16, 8'h1A, 8'h2C, 8'h05, 8'h04};

    tetris_input_ctrl #(.DAS_FRAMES(DAS), .ARR_FRAMES(ARR)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .keycode      (keycode),
        .frame_tick   (frame_tick),
        .action       (action),
        .action_valid (action_valid),
        .action_ready (action_ready),
        .dbg_state    (dbg_state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [2:0] map_key(input logic [7:0] k);
        case (k)
            8'h04:   return 3'd1;
            8'h07:   return 3'd2;
            8'h16:   return 3'd3;
            8'h1A:   return 3'd4;
            8'h2C:   return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: evaluated at the falling edge with the inputs the next rising
    // edge will sample, so its state after the update is the post-edge view.
    always @(negedge Clk) begin
        exp_valid_now = m_valid;
        exp_data_now  = m_data;
        m_acc = m_valid && action_ready;
        if (m_acc) exp_q.push_back(m_data);
        if (Reset) begin
            m_valid = 1'b0; m_data = 3'd0; mk_q = 8'h00; mk_prev = 8'h00;
            m_held = 3'd0; m_ticks = 0;
        end else begin
            m_act = map_key(mk_q);
            m_ev  = 1'b0;
            m_evp = 1'b0;
            if (m_act == 3'd0) begin
                m_held = 3'd0;
            end else if (mk_q != mk_prev) begin
                m_ev = 1'b1; m_evp = 1'b1; m_held = m_act; m_ticks = 0;
            end else if (frame_tick && (m_held == 3'd1 || m_held == 3'd2 || m_held == 3'd3)) begin
                m_ticks++;
                if (m_ticks == DAS || (m_ticks > DAS && (m_ticks - DAS) % ARR == 0)) m_ev = 1'b1;
            end
            if (m_acc) m_valid = 1'b0;
            if (m_ev && (m_evp || !m_valid)) begin
                m_valid = 1'b1;
                m_data  = m_act;
            end
            mk_prev = mk_q;
            mk_q    = keycode;
        end
    end

    // Monitor: compares what the DUT presents against the model and pops
    // the expected queue on every transfer.
    always @(negedge Clk) begin
        #1;
        if (!mon_en) begin
            exp_q.delete();
        end else begin
            chk("valid", {31'd0, action_valid}, {31'd0, exp_valid_now});
            if (exp_valid_now) chk("action", {29'd0, action}, {29'd0, exp_data_now});
            if (action_valid === 1'b1 && action_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL xfer_unexpected: got action %0d with no expected transfer at %0t", action, $time);
                end else begin
                    chk("xfer_action", {29'd0, action}, {29'd0, exp_q.pop_front()});
                end
            end
            while (exp_q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL xfer_missing: expected action %0d not transferred at %0t", exp_q.pop_front(), $time);
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic ticks(input int n, input int gap);
        repeat (n) begin
            frame_tick = 1'b1;
            step();
            steps(gap);
        end
    endtask

    int x0;

    initial begin
        Reset = 1'b1;
        keycode = 8'h00;
        frame_tick = 1'b0;
        action_ready = 1'b1;
        steps(3);
        mon_en = 1'b1;
        chk("reset_valid", {31'd0, action_valid}, 32'd0);
        chk("reset_action", {29'd0, action}, 32'd0);

        // Single RIGHT press, then DAS boundary at the tenth tick.
        Reset = 1'b0;
        step();
        x0 = xfer_cnt;
        keycode = 8'h07;
        steps(20);
        chk("right_single", xfer_cnt - x0, 32'd1);
        ticks(9, 2);
        chk("right_before_das", xfer_cnt - x0, 32'd1);
        ticks(1, 2);
        chk("right_at_das", xfer_cnt - x0, 32'd2);
        keycode = 8'h00;
        steps(3);

        // LEFT held for 16 ticks: press plus ticks 10, 12, 14, 16.
        x0 = xfer_cnt;
        keycode = 8'h04;
        steps(2);
        ticks(16, 2);
        keycode = 8'h00;
        steps(3);
        chk("left_repeat_count", xfer_cnt - x0, 32'd5);

        // HARD_DROP never repeats; switching straight to ROTATE is a new press.
        x0 = xfer_cnt;
        keycode = 8'h2C;
        steps(2);
        ticks(30, 1);
        keycode = 8'h1A;
        steps(3);
        ticks(5, 1);
        keycode = 8'h00;
        steps(3);
        chk("hard_then_rotate", xfer_cnt - x0, 32'd2);

        // Stalled consumer: SOFT_DROP stays put, repeats are discarded.
        action_ready = 1'b0;
        keycode = 8'h16;
        steps(2);
        ticks(14, 2);
        chk("stall_valid", {31'd0, action_valid}, 32'd1);
        chk("stall_action", {29'd0, action}, 32'd3);
        keycode = 8'h00;
        steps(3);
        x0 = xfer_cnt;
        action_ready = 1'b1;
        steps(5);
        chk("stall_one_xfer", xfer_cnt - x0, 32'd1);

        // A press overwrites a stalled entry.
        action_ready = 1'b0;
        keycode = 8'h04;
        steps(3);
        keycode = 8'h1A;
        steps(2);
        chk("overwrite_action", {29'd0, action}, 32'd4);
        action_ready = 1'b1;
        keycode = 8'h00;
        steps(3);

        // Reset during REPEAT with a pending entry, key held through it.
        action_ready = 1'b0;
        keycode = 8'h04;
        steps(2);
        ticks(12, 1);
        chk("pre_reset_state", {30'd0, dbg_state}, {30'd0, ST_REPEAT});
        chk("pre_reset_valid", {31'd0, action_valid}, 32'd1);
        Reset = 1'b1;
        step();
        chk("mid_reset_valid", {31'd0, action_valid}, 32'd0);
        chk("mid_reset_action", {29'd0, action}, 32'd0);
        Reset = 1'b0;
        action_ready = 1'b1;
        x0 = xfer_cnt;
        steps(4);
        chk("post_reset_press", xfer_cnt - x0, 32'd1);
        chk("post_reset_state", {30'd0, dbg_state}, {30'd0, ST_DELAY});
        keycode = 8'h00;
        steps(3);

        // Random keys, tick density and consumer behaviour.
        for (int h = 0; h < 150; h++) begin
            int len;
            int rmode;
            keycode = keys[$urandom_range(0, 7)];
            len = $urandom_range(1, 50);
            rmode = $urandom_range(0, 3);
            for (int c = 0; c < len; c++) begin
                frame_tick = ($urandom_range(0, 2) == 0);
                action_ready = (rmode == 0) ? 1'b0 : (rmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
                Reset = ($urandom_range(0, 199) == 0);
                step();
            end
            Reset = 1'b0;
        end
        keycode = 8'h00;
        action_ready = 1'b1;
        steps(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
